// File: rtl/setup_packet_assembler.sv
// rtl/setup_packet_assembler.sv - packs the 8-byte SETUP data stage into a 64-bit word with enable/busy handshake
module setup_packet_assembler #(
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        busy,
  output logic [63:0] data,
  output logic        enable,
  output logic        pkt_err,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_LOAD,
    S_HOLD,
    S_WAIT,
    S_DISCARD
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TIMEOUT - 1);

  state_t      state, state_d;
  logic [3:0]  byte_cnt, byte_cnt_d;
  logic [63:0] shift_buf, shift_buf_d;
  logic [7:0]  hold_cnt, hold_cnt_d;
  logic        dropping, dropping_d;
  logic [63:0] data_d;
  logic        enable_d;
  logic        pkt_err_d;
  logic        overrun_d;
  logic        byte_ok;
  logic        busy_state;
  logic [3:0]  cnt_next;

  // shift_buf holds wire byte i at bits [8*i +: 8]; reorder into USB field layout
  function automatic logic [63:0] pack_setup(input logic [63:0] b);
    return {b[7:0], b[15:8], b[31:24], b[23:16], b[47:40], b[39:32], b[63:56], b[55:48]};
  endfunction

  assign byte_ok    = rx_valid && !dropping;
  assign busy_state = (state == S_LOAD) || (state == S_HOLD) || (state == S_WAIT);
  assign cnt_next   = byte_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= 4'd0;
      shift_buf <= 64'd0;
      hold_cnt  <= 8'd0;
      dropping  <= 1'b0;
      data      <= 64'd0;
      enable    <= 1'b0;
      pkt_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      byte_cnt  <= byte_cnt_d;
      shift_buf <= shift_buf_d;
      hold_cnt  <= hold_cnt_d;
      dropping  <= dropping_d;
      data      <= data_d;
      enable    <= enable_d;
      pkt_err   <= pkt_err_d;
      overrun   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    shift_buf_d = shift_buf;
    hold_cnt_d  = hold_cnt;
    dropping_d  = dropping;
    data_d      = data;
    enable_d    = enable;
    pkt_err_d   = 1'b0;
    overrun_d   = 1'b0;

    // A packet starting while a word is outstanding is swallowed whole
    if (busy_state && rx_valid && rx_sop) begin
      overrun_d  = 1'b1;
      dropping_d = !rx_eop;
    end else if (dropping && rx_valid && rx_eop) begin
      dropping_d = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (byte_ok && rx_sop) begin
          shift_buf_d[7:0] = rx_data;
          byte_cnt_d       = 4'd1;
          if (rx_eop) pkt_err_d = 1'b1;
          else        state_d   = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (byte_ok) begin
          if (rx_sop) begin
            shift_buf_d[7:0] = rx_data;
            byte_cnt_d       = 4'd1;
            pkt_err_d        = 1'b1;
            if (rx_eop) state_d = S_IDLE;
          end else if (byte_cnt == 4'd8) begin
            pkt_err_d = 1'b1;
            state_d   = rx_eop ? S_IDLE : S_DISCARD;
          end else begin
            shift_buf_d[{byte_cnt[2:0], 3'b000} +: 8] = rx_data;
            byte_cnt_d = cnt_next;
            if (rx_eop) begin
              if (cnt_next == 4'd8) begin
                state_d = S_LOAD;
              end else begin
                pkt_err_d = 1'b1;
                state_d   = S_IDLE;
              end
            end
          end
        end
      end

      // One cycle after the eop byte lands, the packed word is published
      S_LOAD: begin
        data_d     = pack_setup(shift_buf);
        enable_d   = 1'b1;
        hold_cnt_d = 8'd0;
        state_d    = S_HOLD;
      end

      S_HOLD: begin
        if (busy) begin
          enable_d = 1'b0;
          state_d  = S_WAIT;
        end else if (hold_cnt == HOLD_LAST) begin
          enable_d  = 1'b0;
          pkt_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt + 8'd1;
        end
      end

      S_WAIT: begin
        if (!busy) state_d = S_IDLE;
      end

      S_DISCARD: begin
        if (rx_valid && rx_eop) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_setup_packet_assembler.sv
// tb/tb_setup_packet_assembler.sv - randomized self-checking bench for setup_packet_assembler
module tb_setup_packet_assembler;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        busy;
  logic [63:0] data;
  logic        enable;
  logic        pkt_err;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0, err_cnt = 0, ovr_cnt = 0;
  int last_en_cyc = 0, last_err_cyc = 0;
  logic [7:0] pkt [0:15];
  int drive_cyc [0:15];
  logic [63:0] exp_word;

  setup_packet_assembler #(.HOLD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .busy(busy), .data(data),
    .enable(enable), .pkt_err(pkt_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enable)  begin en_cnt++;  last_en_cyc = cyc;  end
    if (pkt_err) begin err_cnt++; last_err_cyc = cyc; end
    if (overrun) ovr_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Setup word from wire bytes, built from the USB field definitions
  function automatic logic [63:0] model_word(input int base);
    logic [63:0] w_value, w_index, w_length;
    w_value  = 64'(pkt[base+2]) + 64'(pkt[base+3]) * 256;
    w_index  = 64'(pkt[base+4]) + 64'(pkt[base+5]) * 256;
    w_length = 64'(pkt[base+6]) + 64'(pkt[base+7]) * 256;
    return (64'(pkt[base]) << 56) | (64'(pkt[base+1]) << 48) | (w_value << 32) | (w_index << 16) | w_length;
  endfunction

  task automatic send_pkt(input int n, input int stop, input bit gaps);
    for (int i = 0; i < stop; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          rx_valid = 1'b0; rx_data = 8'($urandom); rx_sop = 1'($urandom); rx_eop = 1'($urandom);
          tick();
        end
      end
      rx_valid = 1'b1; rx_data = pkt[i]; rx_sop = (i == 0); rx_eop = (i == n - 1);
      drive_cyc[i] = cyc;
      tick();
    end
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic wait_enable(output int lat);
    lat = 0;
    while (!enable && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_enable_low(output bit ok);
    int n = 0;
    while (enable && n < 40) begin
      tick();
      n++;
    end
    ok = !enable;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = 8'h00; busy = 1'b0;
    tick(); tick();
    checks++; if (data !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
    checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL reset_pkt_err got=%b exp=0", pkt_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int lat, e0, r0, o0;
    bit ok;
    logic [7:0] b [0:7] = '{8'hA1, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    for (int i = 0; i < 8; i++) pkt[i] = b[i];
    e0 = en_cnt; r0 = err_cnt; o0 = ovr_cnt;
    send_pkt(8, 8, 1'b0);
    wait_enable(lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL nominal_latency got=%0d exp=1", lat); end
    checks++; if (data !== 64'hA187_0000_0000_0002) begin failures++; $display("FAIL nominal_data got=%h exp=a187000000000002", data); end
    tick(); tick();
    busy = 1'b1;
    wait_enable_low(ok);
    checks++; if (!ok || en_cnt - e0 !== 3) begin failures++; $display("FAIL nominal_enable_cycles got=%0d exp=3", en_cnt - e0); end
    busy = 1'b0;
    tick(); tick();
    checks++; if (err_cnt - r0 !== 0) begin failures++; $display("FAIL nominal_pkt_err got=%0d exp=0", err_cnt - r0); end
    checks++; if (ovr_cnt - o0 !== 0) begin failures++; $display("FAIL nominal_overrun got=%0d exp=0", ovr_cnt - o0); end
    exp_word = 64'hA187_0000_0000_0002;
  endtask

  task automatic test_short();
    int e0, r0;
    for (int i = 0; i < 6; i++) pkt[i] = 8'($urandom);
    e0 = en_cnt; r0 = err_cnt;
    send_pkt(6, 6, 1'b1);
    repeat (4) tick();
    checks++; if (err_cnt - r0 !== 1) begin failures++; $display("FAIL short_pkt_err got=%0d exp=1", err_cnt - r0); end
    checks++; if (en_cnt - e0 !== 0) begin failures++; $display("FAIL short_enable got=%0d exp=0", en_cnt - e0); end
    checks++; if (data !== exp_word) begin failures++; $display("FAIL short_data got=%h exp=%h", data, exp_word); end
  endtask

  task automatic test_long();
    int e0, r0;
    for (int i = 0; i < 10; i++) pkt[i] = 8'($urandom);
    e0 = en_cnt; r0 = err_cnt;
    send_pkt(10, 10, 1'b0);
    repeat (4) tick();
    checks++; if (err_cnt - r0 !== 1) begin failures++; $display("FAIL long_pkt_err got=%0d exp=1", err_cnt - r0); end
    checks++; if (last_err_cyc !== drive_cyc[8] + 1) begin failures++; $display("FAIL long_err_timing got=%0d exp=%0d", last_err_cyc, drive_cyc[8] + 1); end
    checks++; if (en_cnt - e0 !== 0 || data !== exp_word) begin failures++; $display("FAIL long_no_word got_en=%0d data=%h exp_data=%h", en_cnt - e0, data, exp_word); end
  endtask

  task automatic test_timeout();
    int lat, e0, r0;
    bit ok;
    for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
    e0 = en_cnt; r0 = err_cnt;
    send_pkt(8, 8, 1'b1);
    wait_enable(lat);
    wait_enable_low(ok);
    tick();
    exp_word = model_word(0);
    checks++; if (!ok || en_cnt - e0 !== TO) begin failures++; $display("FAIL timeout_enable_cycles got=%0d exp=%0d", en_cnt - e0, TO); end
    checks++; if (err_cnt - r0 !== 1) begin failures++; $display("FAIL timeout_pkt_err got=%0d exp=1", err_cnt - r0); end
    checks++; if (last_err_cyc !== last_en_cyc + 1) begin failures++; $display("FAIL timeout_err_timing got=%0d exp=%0d", last_err_cyc, last_en_cyc + 1); end
    checks++; if (data !== exp_word) begin failures++; $display("FAIL timeout_data got=%h exp=%h", data, exp_word); end
  endtask

  task automatic test_overrun();
    int lat, e0, r0, o0;
    bit ok;
    for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
    exp_word = model_word(0);
    e0 = en_cnt; r0 = err_cnt; o0 = ovr_cnt;
    send_pkt(8, 8, 1'b0);
    wait_enable(lat);
    busy = 1'b1;
    wait_enable_low(ok);
    tick();
    for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
    send_pkt(8, 8, 1'b1);
    repeat (3) tick();
    busy = 1'b0;
    tick(); tick();
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL overrun_pulse got=%0d exp=1", ovr_cnt - o0); end
    checks++; if (data !== exp_word) begin failures++; $display("FAIL overrun_data got=%h exp=%h", data, exp_word); end
    checks++; if (en_cnt - e0 !== 1) begin failures++; $display("FAIL overrun_enable_cycles got=%0d exp=1", en_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin failures++; $display("FAIL overrun_pkt_err got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
    send_pkt(8, 4, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (data !== 64'd0 || enable !== 1'b0 || pkt_err !== 1'b0 || overrun !== 1'b0)
      begin failures++; $display("FAIL reset_mid_outputs got data=%h en=%b err=%b ovr=%b exp=all0", data, enable, pkt_err, overrun); end
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
    exp_word = model_word(0);
    send_pkt(8, 8, 1'b0);
    wait_enable(lat);
    checks++; if (!enable || data !== exp_word) begin failures++; $display("FAIL reset_mid_data got=%h en=%b exp=%h", data, enable, exp_word); end
    busy = 1'b1;
    wait_enable_low(ok);
    busy = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int n, lat, wl, e0, r0, o0, exp_en, exp_err;
      bit ok;
      n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 11) : 8;
      lat = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
      e0 = en_cnt; r0 = err_cnt; o0 = ovr_cnt;
      if (n == 8) begin
        exp_word = model_word(0);
        exp_en = (lat == 0) ? 1 : ((lat <= TO) ? lat : TO);
        exp_err = (lat > TO) ? 1 : 0;
        if (lat == 0) busy = 1'b1;
        send_pkt(n, n, 1'b1);
        wait_enable(wl);
        checks++; if (!enable || data !== exp_word) begin failures++; $display("FAIL rand_data pkt=%0d got=%h exp=%h", k, data, exp_word); end
        if (lat >= 1 && lat <= TO) begin
          repeat (lat - 1) tick();
          busy = 1'b1;
        end
        wait_enable_low(ok);
        tick();
        busy = 1'b0;
        tick(); tick();
      end else begin
        exp_en = 0;
        exp_err = 1;
        send_pkt(n, n, 1'b1);
        repeat (3) tick();
      end
      checks++; if (en_cnt - e0 !== exp_en) begin failures++; $display("FAIL rand_enable_cycles pkt=%0d len=%0d got=%0d exp=%0d", k, n, en_cnt - e0, exp_en); end
      checks++; if (err_cnt - r0 !== exp_err || ovr_cnt - o0 !== 0) begin failures++; $display("FAIL rand_pulses pkt=%0d len=%0d err=%0d exp=%0d ovr=%0d exp=0", k, n, err_cnt - r0, exp_err, ovr_cnt - o0); end
      checks++; if (data !== exp_word) begin failures++; $display("FAIL rand_data_hold pkt=%0d got=%h exp=%h", k, data, exp_word); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
